// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter_if: requester, bus and response signals of the arbiter.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_port_arbiter_if;
  logic        ifetch_req_valid_i;
  logic        ifetch_req_ready_o;
  logic [31:0] ifetch_req_address_i;
  logic        ifetch_rsp_valid_o;
  logic [31:0] ifetch_rsp_data_o;
  logic        data_req_valid_i;
  logic        data_req_ready_o;
  logic [31:0] data_req_address_i;
  logic        data_req_write_i;
  logic [31:0] data_req_write_data_i;
  logic [3:0]  data_req_byte_enable_i;
  logic        data_rsp_valid_o;
  logic [31:0] data_rsp_data_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [31:0] mem_req_address_o;
  logic        mem_req_write_o;
  logic [31:0] mem_req_write_data_o;
  logic [3:0]  mem_req_byte_enable_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;

  // The arbiter is the slave; requesters and memory together form the master side.
  modport slave (
    input  ifetch_req_valid_i, ifetch_req_address_i,
    output ifetch_req_ready_o, ifetch_rsp_valid_o, ifetch_rsp_data_o,
    input  data_req_valid_i, data_req_address_i, data_req_write_i,
    input  data_req_write_data_i, data_req_byte_enable_i,
    output data_req_ready_o, data_rsp_valid_o, data_rsp_data_o,
    output mem_req_valid_o, mem_req_address_o, mem_req_write_o,
    output mem_req_write_data_o, mem_req_byte_enable_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );

  modport master (
    output ifetch_req_valid_i, ifetch_req_address_i,
    input  ifetch_req_ready_o, ifetch_rsp_valid_o, ifetch_rsp_data_o,
    output data_req_valid_i, data_req_address_i, data_req_write_i,
    output data_req_write_data_i, data_req_byte_enable_i,
    input  data_req_ready_o, data_rsp_valid_o, data_rsp_data_o,
    input  mem_req_valid_o, mem_req_address_o, mem_req_write_o,
    input  mem_req_write_data_o, mem_req_byte_enable_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rsp_data_i
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between ifetch and data, one      |
// | outstanding transaction. Optional macro: MEM_ARB_STARVATION_GUARD_EN.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int StarvationLimit = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam logic [1:0] c_IDLE       = 2'd0;
  localparam logic [1:0] c_REQ        = 2'd1;
  localparam logic [1:0] c_RSP        = 2'd2;
  localparam logic [1:0] c_OWN_NONE   = 2'd0;
  localparam logic [1:0] c_OWN_IFETCH = 2'd1;
  localparam logic [1:0] c_OWN_DATA   = 2'd2;

  if ((StarvationLimit < 1) || (StarvationLimit > 15)) begin : g_limit_check
    $error("mem_port_arbiter: StarvationLimit must be within 1..15");
  end

  logic [1:0]  state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic [3:0]  be_q, be_d;

  logic in_idle;
  logic force_ifetch;
  logic grant_data;
  logic grant_ifetch;
  logic rsp_fire;
  logic ifetch_rsp_fire;
  logic data_rsp_fire;

  // Readiness is suppressed while reset is held so nothing is accepted then.
  assign in_idle      = (state_q == c_IDLE) && !rst_i;
  assign grant_data   = in_idle && bus.data_req_valid_i && !force_ifetch;
  assign grant_ifetch = in_idle && bus.ifetch_req_valid_i && !grant_data;

`ifdef MEM_ARB_STARVATION_GUARD_EN
  localparam logic [3:0] c_LIMIT = 4'(StarvationLimit);

  logic [3:0] starve_q, starve_d;

  assign force_ifetch = bus.ifetch_req_valid_i && (starve_q == c_LIMIT);

  always_comb begin
    starve_d = starve_q;
    if (grant_ifetch) begin
      starve_d = 4'd0;
    end else if (grant_data && bus.ifetch_req_valid_i && (starve_q != c_LIMIT)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_ifetch = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    be_d    = be_q;
    case (state_q)
      c_IDLE: begin
        if (grant_data) begin
          state_d = c_REQ;
          owner_d = c_OWN_DATA;
          addr_d  = bus.data_req_address_i;
          write_d = bus.data_req_write_i;
          // Loads present as full-word reads with no write payload.
          wdata_d = bus.data_req_write_i ? bus.data_req_write_data_i : 32'd0;
          be_d    = bus.data_req_write_i ? bus.data_req_byte_enable_i : 4'hF;
        end else if (grant_ifetch) begin
          state_d = c_REQ;
          owner_d = c_OWN_IFETCH;
          addr_d  = bus.ifetch_req_address_i;
          write_d = 1'b0;
          wdata_d = 32'd0;
          be_d    = 4'hF;
        end
      end
      c_REQ: begin
        if (bus.mem_req_ready_i) begin
          state_d = c_RSP;
        end
      end
      c_RSP: begin
        if (bus.mem_rsp_valid_i) begin
          state_d = c_IDLE;
          owner_d = c_OWN_NONE;
        end
      end
      default: begin
        state_d = c_IDLE;
        owner_d = c_OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= c_IDLE;
      owner_q <= c_OWN_NONE;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      be_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      be_q    <= be_d;
    end
  end

  assign bus.ifetch_req_ready_o    = grant_ifetch;
  assign bus.data_req_ready_o      = grant_data;

  assign bus.mem_req_valid_o       = (state_q == c_REQ);
  assign bus.mem_req_address_o     = addr_q;
  assign bus.mem_req_write_o       = write_q;
  assign bus.mem_req_write_data_o  = wdata_q;
  assign bus.mem_req_byte_enable_o = be_q;

  assign rsp_fire        = (state_q == c_RSP) && bus.mem_rsp_valid_i;
  assign ifetch_rsp_fire = rsp_fire && (owner_q == c_OWN_IFETCH);
  assign data_rsp_fire   = rsp_fire && (owner_q == c_OWN_DATA);

  assign bus.ifetch_rsp_valid_o = ifetch_rsp_fire;
  assign bus.ifetch_rsp_data_o  = ifetch_rsp_fire ? bus.mem_rsp_data_i : 32'd0;
  assign bus.data_rsp_valid_o   = data_rsp_fire;
  assign bus.data_rsp_data_o    = data_rsp_fire ? bus.mem_rsp_data_i : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int c_LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.StarvationLimit(c_LIMIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    int          owner;
    logic [31:0] data;
    bit          chk;
  } rsp_t;

  req_t        exp_req_q[$];
  rsp_t        exp_rsp_q[$];
  byte         exp_grant_q[$];
  logic [31:0] rsp_word_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit resp_en = 1'b0;
  int stall_cycles = 0;
  int last_req_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected output 0x%08h with nothing expected", name, act);
  endtask

  task automatic expect_fetch(input logic [31:0] addr, input logic [31:0] word);
    exp_req_q.push_back('{addr: addr, wr: 1'b0, wd: 32'd0, be: 4'hF});
    exp_rsp_q.push_back('{owner: 1, data: word, chk: 1'b1});
    exp_grant_q.push_back("I");
    rsp_word_q.push_back(word);
  endtask

  task automatic expect_load(input logic [31:0] addr, input logic [31:0] word);
    exp_req_q.push_back('{addr: addr, wr: 1'b0, wd: 32'd0, be: 4'hF});
    exp_rsp_q.push_back('{owner: 2, data: word, chk: 1'b1});
    exp_grant_q.push_back("D");
    rsp_word_q.push_back(word);
  endtask

  task automatic expect_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    exp_req_q.push_back('{addr: addr, wr: 1'b1, wd: wd, be: be});
    exp_rsp_q.push_back('{owner: 2, data: 32'd0, chk: 1'b0});
    exp_grant_q.push_back("D");
    rsp_word_q.push_back(32'd0);
  endtask

  // Waits for the chosen ready, returns the number of negedges before it, realigns to posedge+1.
  task automatic wait_ready(input bit is_data, input string name, output int cycles);
    bit got = 1'b0;
    cycles = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (is_data ? bus.data_req_ready_o : bus.ifetch_req_ready_o) begin
        got = 1'b1;
        cycles = k;
        break;
      end
    end
    check(name, 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 100 && (exp_req_q.size() + exp_rsp_q.size()) != 0; k++) begin
      @(negedge clk);
    end
    check(name, 32'(exp_req_q.size() + exp_rsp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every DUT presentation against the scoreboard queues.
  initial begin : monitor
    int   held;
    int   own;
    byte  g;
    byte  eg;
    rsp_t e;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        check("ready_exclusive", 32'(bus.ifetch_req_ready_o & bus.data_req_ready_o), 32'd0);
        if (bus.ifetch_req_ready_o || bus.data_req_ready_o) begin
          g = bus.data_req_ready_o ? "D" : "I";
          if (exp_grant_q.size() == 0) begin
            unexpected("grant_extra", 32'(g));
          end else begin
            eg = exp_grant_q.pop_front();
            check("grant_owner", 32'(g), 32'(eg));
          end
        end
        if (bus.mem_req_valid_o) begin
          held++;
          if (exp_req_q.size() == 0) begin
            unexpected("mem_req_extra", bus.mem_req_address_o);
          end else begin
            check("mem_req_addr", bus.mem_req_address_o, exp_req_q[0].addr);
            check("mem_req_write", 32'(bus.mem_req_write_o), 32'(exp_req_q[0].wr));
            check("mem_req_be", 32'(bus.mem_req_byte_enable_o), 32'(exp_req_q[0].be));
            if (exp_req_q[0].wr) begin
              check("mem_req_wdata", bus.mem_req_write_data_o, exp_req_q[0].wd);
            end
            if (bus.mem_req_ready_i) begin
              void'(exp_req_q.pop_front());
              last_req_cycles = held;
              held = 0;
            end
          end
        end
        check("rsp_exclusive", 32'(bus.ifetch_rsp_valid_o & bus.data_rsp_valid_o), 32'd0);
        if (bus.ifetch_rsp_valid_o || bus.data_rsp_valid_o) begin
          own = bus.data_rsp_valid_o ? 2 : 1;
          if (exp_rsp_q.size() == 0) begin
            unexpected("rsp_extra", 32'(own));
          end else begin
            e = exp_rsp_q.pop_front();
            check("rsp_owner", 32'(own), 32'(e.owner));
            if (e.chk) begin
              check("rsp_data", (own == 2) ? bus.data_rsp_data_o : bus.ifetch_rsp_data_o, e.data);
            end
          end
        end
        if (!bus.ifetch_rsp_valid_o) check("ifetch_rsp_data_idle", bus.ifetch_rsp_data_o, 32'd0);
        if (!bus.data_rsp_valid_o) check("data_rsp_data_idle", bus.data_rsp_data_o, 32'd0);
      end
    end
  end

  // Memory model: stalls ready for stall_cycles, answers the cycle after acceptance.
  initial begin : responder
    int stall;
    bit pend;
    stall = 0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_en) begin
        bus.mem_req_ready_i = 1'b0;
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_data_i  = 32'd0;
        if (pend) begin
          bus.mem_rsp_valid_i = 1'b1;
          bus.mem_rsp_data_i  = (rsp_word_q.size() != 0) ? rsp_word_q.pop_front() : 32'd0;
          pend = 1'b0;
        end else if (bus.mem_req_valid_o) begin
          if (stall < stall_cycles) begin
            stall++;
          end else begin
            bus.mem_req_ready_i = 1'b1;
            stall = 0;
            pend = 1'b1;
          end
        end
      end else begin
        stall = 0;
        pend = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int    cyc;
    int    n;
    string pat;

    bus.ifetch_req_valid_i     = 1'b0;
    bus.ifetch_req_address_i   = 32'd0;
    bus.data_req_valid_i       = 1'b1;
    bus.data_req_address_i     = 32'h1234_5678;
    bus.data_req_write_i       = 1'b0;
    bus.data_req_write_data_i  = 32'd0;
    bus.data_req_byte_enable_i = 4'd0;
    bus.mem_req_ready_i        = 1'b0;
    bus.mem_rsp_valid_i        = 1'b0;
    bus.mem_rsp_data_i         = 32'd0;

    // Reset state, with a data request already pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data_ready", 32'(bus.data_req_ready_o), 32'd0);
    check("rst_ifetch_ready", 32'(bus.ifetch_req_ready_o), 32'd0);
    check("rst_mem_valid", 32'(bus.mem_req_valid_o), 32'd0);
    check("rst_mem_addr", bus.mem_req_address_o, 32'd0);
    check("rst_mem_be", 32'(bus.mem_req_byte_enable_o), 32'd0);
    check("rst_rsp_valid", 32'(bus.ifetch_rsp_valid_o | bus.data_rsp_valid_o), 32'd0);
    bus.data_req_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resp_en = 1'b1;

    // Single fetch, minimum latency.
    expect_fetch(32'h0000_0100, 32'h0000_0013);
    bus.ifetch_req_valid_i   = 1'b1;
    bus.ifetch_req_address_i = 32'h0000_0100;
    @(negedge clk);
    check("fetch_ready_c0", 32'(bus.ifetch_req_ready_o), 32'd1);
    check("fetch_data_ready_c0", 32'(bus.data_req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    bus.ifetch_req_valid_i = 1'b0;
    @(negedge clk);
    check("fetch_mem_valid_c1", 32'(bus.mem_req_valid_o), 32'd1);
    @(negedge clk);
    check("fetch_rsp_valid_c2", 32'(bus.ifetch_rsp_valid_o), 32'd1);
    check("fetch_rsp_data_c2", bus.ifetch_rsp_data_o, 32'h0000_0013);
    check("fetch_no_data_rsp_c2", 32'(bus.data_rsp_valid_o), 32'd0);
    drain("fetch_drain");

    // Simultaneous: load first, ifetch the cycle after the load response.
    expect_load(32'h8000_0000, 32'hCAFE_0001);
    expect_fetch(32'h0000_0200, 32'h0000_0093);
    bus.ifetch_req_valid_i   = 1'b1;
    bus.ifetch_req_address_i = 32'h0000_0200;
    bus.data_req_valid_i     = 1'b1;
    bus.data_req_address_i   = 32'h8000_0000;
    bus.data_req_write_i     = 1'b0;
    @(negedge clk);
    check("sim_data_ready", 32'(bus.data_req_ready_o), 32'd1);
    check("sim_ifetch_held", 32'(bus.ifetch_req_ready_o), 32'd0);
    @(posedge clk);
    #1;
    bus.data_req_valid_i = 1'b0;
    wait_ready(1'b0, "sim_ifetch_grant", cyc);
    bus.ifetch_req_valid_i = 1'b0;
    check("sim_ifetch_grant_cycle", 32'(cyc), 32'd2);
    drain("sim_drain");

    // Store under bus backpressure.
    stall_cycles = 3;
    expect_store(32'h8000_0004, 32'hDEAD_BEEF, 4'b0011);
    bus.data_req_valid_i       = 1'b1;
    bus.data_req_address_i     = 32'h8000_0004;
    bus.data_req_write_i       = 1'b1;
    bus.data_req_write_data_i  = 32'hDEAD_BEEF;
    bus.data_req_byte_enable_i = 4'b0011;
    wait_ready(1'b1, "store_grant", cyc);
    bus.data_req_valid_i = 1'b0;
    bus.data_req_write_i = 1'b0;
    drain("store_drain");
    check("store_req_hold_cycles", 32'(last_req_cycles), 32'd4);
    stall_cycles = 0;

    // Stray responses in IDLE and REQ.
    resp_en = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'hFFFF_FFFF;
    @(negedge clk);
    check("stray_idle_rsp", 32'(bus.ifetch_rsp_valid_o | bus.data_rsp_valid_o), 32'd0);
    check("stray_idle_mem_valid", 32'(bus.mem_req_valid_o), 32'd0);
    @(posedge clk);
    #1;
    bus.mem_rsp_valid_i = 1'b0;
    expect_fetch(32'h0000_0400, 32'h1234_5678);
    bus.ifetch_req_valid_i   = 1'b1;
    bus.ifetch_req_address_i = 32'h0000_0400;
    wait_ready(1'b0, "stray_fetch_grant", cyc);
    bus.ifetch_req_valid_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'hFFFF_FFFF;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("stray_req_mem_valid", 32'(bus.mem_req_valid_o), 32'd1);
      check("stray_req_rsp", 32'(bus.ifetch_rsp_valid_o | bus.data_rsp_valid_o), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = rsp_word_q.pop_front();
    @(negedge clk);
    check("stray_final_rsp", 32'(bus.ifetch_rsp_valid_o), 32'd1);
    @(posedge clk);
    #1;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = 32'd0;
    drain("stray_drain");

    // Reset while waiting for a response; the late response is dropped.
    exp_req_q.push_back('{addr: 32'h0000_0500, wr: 1'b0, wd: 32'd0, be: 4'hF});
    exp_grant_q.push_back("I");
    bus.ifetch_req_valid_i   = 1'b1;
    bus.ifetch_req_address_i = 32'h0000_0500;
    wait_ready(1'b0, "rstmid_grant", cyc);
    bus.ifetch_req_valid_i = 1'b0;
    bus.mem_req_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_req_ready_i = 1'b0;
    @(negedge clk);
    check("rstmid_in_rsp", 32'(bus.mem_req_valid_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_data_i  = 32'hAAAA_5555;
    #1;
    check("rstmid_rsp_valid", 32'(bus.ifetch_rsp_valid_o | bus.data_rsp_valid_o), 32'd0);
    check("rstmid_rsp_data", bus.ifetch_rsp_data_o, 32'd0);
    check("rstmid_mem_valid", 32'(bus.mem_req_valid_o), 32'd0);
    check("rstmid_mem_addr", bus.mem_req_address_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_late_rsp", 32'(bus.ifetch_rsp_valid_o | bus.data_rsp_valid_o), 32'd0);
    check("rstmid_late_data", bus.ifetch_rsp_data_o, 32'd0);
    @(posedge clk);
    #1;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_data_i  = 32'd0;

    // Both requesters continuously valid.
    resp_en = 1'b1;
`ifdef MEM_ARB_STARVATION_GUARD_EN
    pat = "DDDDIDDDDI";
`else
    pat = "DDDDDDDDDD";
`endif
    for (int k = 0; k < 10; k++) begin
      if (pat[k] == "D") expect_load(32'h8000_0100, 32'h0000_1000 + 32'(k));
      else               expect_fetch(32'h0000_0300, 32'h0000_1000 + 32'(k));
    end
    bus.ifetch_req_valid_i   = 1'b1;
    bus.ifetch_req_address_i = 32'h0000_0300;
    bus.data_req_valid_i     = 1'b1;
    bus.data_req_address_i   = 32'h8000_0100;
    bus.data_req_write_i     = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge clk);
      if (bus.ifetch_req_ready_o || bus.data_req_ready_o) n++;
    end
    @(posedge clk);
    #1;
    bus.ifetch_req_valid_i = 1'b0;
    bus.data_req_valid_i   = 1'b0;
    check("guard_grant_count", 32'(n), 32'd10);
    drain("guard_drain");

    check("grants_left", 32'(exp_grant_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
